// File: rtl/friet_permutation_host_driver.sv
// Host-side master for the Friet permutation core: serializes a parallel state into the
// core, pulses start, waits for finish, deserializes the result and reports WAIT cycles.
module friet_permutation_host_driver #(
  parameter int unsigned BUFFER_LENGTH = 8,
  parameter int unsigned STATE_SIZE    = 384,
  parameter int unsigned CYCLE_WIDTH   = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [STATE_SIZE-1:0]    i_req_state,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [STATE_SIZE-1:0]    o_rsp_state,
  output logic [CYCLE_WIDTH-1:0]   o_perf_cycles,
  output logic                     o_core_start,
  output logic [BUFFER_LENGTH-1:0] o_core_data_in,
  output logic                     o_core_data_in_valid,
  input  logic                     i_core_data_in_ready,
  input  logic [BUFFER_LENGTH-1:0] i_core_data_out,
  input  logic                     i_core_data_out_valid,
  output logic                     o_core_data_out_ready,
  input  logic                     i_core_finish,
  input  logic                     i_core_free
);

  localparam int unsigned NB    = STATE_SIZE / BUFFER_LENGTH;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_READ,
    S_RESP
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [STATE_SIZE-1:0]    r_shreg;
  logic [STATE_SIZE-1:0]    r_rsp_state;
  logic [CYCLE_WIDTH-1:0]   r_perf;
  logic [CNT_W-1:0]         r_beat;
  logic                     w_last_beat;
  logic                     w_accept;
  logic                     w_in_fire;
  logic                     w_out_fire;

  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_in_fire   = (r_state == S_LOAD) & i_core_data_in_ready;
  assign w_out_fire  = (r_state == S_READ) & i_core_data_out_valid;

  assign o_core_data_in = r_shreg[BUFFER_LENGTH-1:0];
  assign o_rsp_state    = r_rsp_state;
  assign o_perf_cycles  = r_perf;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; reset forces every output low
  always_comb begin
    w_state_nxt           = r_state;
    o_req_ready           = 1'b0;
    o_core_start          = 1'b0;
    o_core_data_in_valid  = 1'b0;
    o_core_data_out_ready = 1'b0;
    o_rsp_valid           = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = i_core_data_in_ready & i_core_free;
        if (i_req_valid & o_req_ready) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        o_core_data_in_valid = 1'b1;
        if (i_core_data_in_ready & w_last_beat) w_state_nxt = S_START;
      end
      S_START: begin
        o_core_start = 1'b1;
        w_state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_finish) w_state_nxt = S_READ;
      end
      S_READ: begin
        o_core_data_out_ready = 1'b1;
        if (i_core_data_out_valid & w_last_beat) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_rst) begin
      w_state_nxt           = S_IDLE;
      o_req_ready           = 1'b0;
      o_core_start          = 1'b0;
      o_core_data_in_valid  = 1'b0;
      o_core_data_out_ready = 1'b0;
      o_rsp_valid           = 1'b0;
    end
  end

  // Datapath: shift registers, beat counter, WAIT cycle counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shreg     <= '0;
      r_rsp_state <= '0;
      r_perf      <= '0;
      r_beat      <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_shreg <= i_req_state;
        r_beat  <= '0;
      end
      if (w_in_fire) begin
        r_shreg <= r_shreg >> BUFFER_LENGTH;
        r_beat  <= w_last_beat ? '0 : r_beat + CNT_W'(1);
      end
      if (r_state == S_START) begin
        r_perf <= '0;
      end
      if (r_state == S_WAIT && r_perf != {CYCLE_WIDTH{1'b1}}) begin
        r_perf <= r_perf + CYCLE_WIDTH'(1);
      end
      // First chunk enters at the top and ends at the bottom after NB beats
      if (w_out_fire) begin
        r_rsp_state <= {i_core_data_out, r_rsp_state[STATE_SIZE-1:BUFFER_LENGTH]};
        r_beat      <= w_last_beat ? '0 : r_beat + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_friet_permutation_host_driver.sv
// Directed bench for friet_permutation_host_driver: load ordering, stalls, WAIT count,
// readback ordering, response backpressure and mid-operation reset.
module tb_friet_permutation_host_driver;

  localparam int unsigned B  = 8;
  localparam int unsigned S  = 384;
  localparam int unsigned CW = 32;
  localparam int unsigned NB = S / B;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [S-1:0]  req_state;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [S-1:0]  rsp_state;
  logic [CW-1:0] perf_cycles;
  logic          core_start;
  logic [B-1:0]  core_data_in;
  logic          core_data_in_valid;
  logic          core_data_in_ready;
  logic [B-1:0]  core_data_out;
  logic          core_data_out_valid;
  logic          core_data_out_ready;
  logic          core_finish;
  logic          core_free;

  int tests = 0;
  int fails = 0;

  logic [S-1:0] pattern_in;
  logic [S-1:0] pattern_out;

  always #5 clk = ~clk;

  friet_permutation_host_driver #(
    .BUFFER_LENGTH(B), .STATE_SIZE(S), .CYCLE_WIDTH(CW)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_req_valid           (req_valid),
    .o_req_ready           (req_ready),
    .i_req_state           (req_state),
    .o_rsp_valid           (rsp_valid),
    .i_rsp_ready           (rsp_ready),
    .o_rsp_state           (rsp_state),
    .o_perf_cycles         (perf_cycles),
    .o_core_start          (core_start),
    .o_core_data_in        (core_data_in),
    .o_core_data_in_valid  (core_data_in_valid),
    .i_core_data_in_ready  (core_data_in_ready),
    .i_core_data_out       (core_data_out),
    .i_core_data_out_valid (core_data_out_valid),
    .o_core_data_out_ready (core_data_out_ready),
    .i_core_finish         (core_finish),
    .i_core_free           (core_free)
  );

  // Present a request at a negedge; returns at the negedge of the first LOAD cycle
  task automatic send_req(input logic [S-1:0] s, output bit ok);
    ok        = 1'b0;
    req_state = s;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // Acts as the core's input side; returns at the negedge where core_start is seen
  task automatic run_load(input bit toggle, output int nbeats, output bit order_ok,
                          output bit stable_ok, output int start_gap,
                          output logic [7:0] first_b, output logic [7:0] last_b);
    int last_cyc;
    bit prev_stall;
    logic [7:0] prev_data;
    bit r;
    nbeats = 0; order_ok = 1'b1; stable_ok = 1'b1; start_gap = -1;
    last_cyc = -100; prev_stall = 1'b0; prev_data = '0;
    first_b = '0; last_b = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (core_start) begin
        start_gap = cyc - last_cyc;
        break;
      end
      r = toggle ? (cyc % 2 == 0) : 1'b1;
      core_data_in_ready = r;
      if (core_data_in_valid) begin
        if (prev_stall && core_data_in !== prev_data) stable_ok = 1'b0;
        if (r) begin
          if (core_data_in !== 8'(nbeats + 1)) order_ok = 1'b0;
          if (nbeats == 0) first_b = core_data_in;
          last_b = core_data_in;
          nbeats++;
          last_cyc = cyc;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_data  = core_data_in;
        end
      end
      @(negedge clk);
    end
    core_data_in_ready = 1'b1;
  endtask

  // Called at the START negedge; finish is raised w cycles later
  task automatic run_wait(input int w, output bit extra_start);
    extra_start = 1'b0;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      if (core_start) extra_start = 1'b1;
    end
    core_finish = 1'b1;
    @(negedge clk);
    core_finish = 1'b0;
  endtask

  // Returns bytes A0+i; with gap, valid drops every third cycle
  task automatic run_read(input bit gap, input int nmax, output int nbeats);
    bit v;
    bit acc;
    nbeats = 0;
    for (int cyc = 0; cyc < 300 && nbeats < nmax; cyc++) begin
      v = gap ? (cyc % 3 != 2) : 1'b1;
      core_data_out_valid = v;
      core_data_out       = 8'(8'hA0 + nbeats);
      acc = v && core_data_out_ready;
      @(negedge clk);
      if (acc) nbeats++;
    end
    core_data_out_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({req_ready, rsp_valid, core_start, core_data_in_valid, core_data_out_ready} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {req_ready, rsp_valid, core_start, core_data_in_valid, core_data_out_ready});
    end
    tests++;
    if (perf_cycles !== '0 || rsp_state !== '0 || core_data_in !== '0) begin
      fails++;
      $display("FAIL reset_data: perf=%0d rsp_nonzero=%0b din=%h expected all 0",
               perf_cycles, rsp_state != '0, core_data_in);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_load_no_stall;
    bit ok, order_ok, stable_ok, extra;
    int nb, gap, nr;
    logic [7:0] fb, lb;
    send_req(pattern_in, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL nostall_accept: got 0 expected 1"); end
    run_load(1'b0, nb, order_ok, stable_ok, gap, fb, lb);
    tests++;
    if (nb !== 48 || !order_ok) begin
      fails++;
      $display("FAIL nostall_beats: got %0d order_ok=%0b expected 48 order_ok=1", nb, order_ok);
    end
    tests++;
    if (fb !== 8'h01 || lb !== 8'h30) begin
      fails++;
      $display("FAIL nostall_first_last: got %h/%h expected 01/30", fb, lb);
    end
    tests++;
    if (gap !== 1) begin
      fails++;
      $display("FAIL nostall_start_gap: got %0d expected 1", gap);
    end
    run_wait(5, extra);
    tests++;
    if (extra) begin fails++; $display("FAIL start_pulse_width: got extra start expected single"); end
    run_read(1'b0, 48, nr);
    tests++;
    if (nr !== 48 || rsp_valid !== 1'b1 || perf_cycles !== 32'd5 || rsp_state !== pattern_out) begin
      fails++;
      $display("FAIL nostall_resp: beats=%0d valid=%b perf=%0d match=%0b expected 48 1 5 1",
               nr, rsp_valid, perf_cycles, rsp_state === pattern_out);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL nostall_idle: valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_stall_wait_read;
    bit ok, order_ok, stable_ok, extra;
    int nb, gap, nr;
    logic [7:0] fb, lb;
    send_req(pattern_in, ok);
    run_load(1'b1, nb, order_ok, stable_ok, gap, fb, lb);
    tests++;
    if (!ok || nb !== 48 || !order_ok) begin
      fails++;
      $display("FAIL stall_beats: got %0d order_ok=%0b expected 48 order_ok=1", nb, order_ok);
    end
    tests++;
    if (!stable_ok) begin fails++; $display("FAIL stall_stable: got unstable expected stable"); end
    tests++;
    if (gap !== 1) begin fails++; $display("FAIL stall_start_gap: got %0d expected 1", gap); end
    run_wait(12, extra);
    run_read(1'b1, 48, nr);
    tests++;
    if (nr !== 48 || rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL gap_read: beats=%0d valid=%b expected 48 1", nr, rsp_valid);
    end
    tests++;
    if (perf_cycles !== 32'd12) begin
      fails++;
      $display("FAIL perf_cycles: got %0d expected 12", perf_cycles);
    end
    tests++;
    if (rsp_state[7:0] !== 8'hA0 || rsp_state[383:376] !== 8'hCF) begin
      fails++;
      $display("FAIL rsp_ends: got %h/%h expected a0/cf", rsp_state[7:0], rsp_state[383:376]);
    end
    tests++;
    if (rsp_state !== pattern_out) begin
      fails++;
      $display("FAIL rsp_full: got %h expected %h", rsp_state, pattern_out);
    end
  endtask

  // Continues from RESP left by the previous task
  task automatic test_resp_backpressure;
    logic [S-1:0] saved;
    bit stable;
    saved  = rsp_state;
    stable = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_state !== saved || req_ready !== 1'b0) stable = 1'b0;
    end
    tests++;
    if (!stable) begin
      fails++;
      $display("FAIL resp_hold: valid=%b ready=%b expected 1 0 with stable state", rsp_valid, req_ready);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || core_data_in_valid !== 1'b0) begin
      fails++;
      $display("FAIL resp_to_idle: valid=%b ready=%b din_valid=%b expected 0 1 0",
               rsp_valid, req_ready, core_data_in_valid);
    end
  endtask

  task automatic test_reset_mid_read;
    bit ok, order_ok, stable_ok, extra;
    int nb, gap, nr;
    logic [7:0] fb, lb;
    send_req(pattern_in, ok);
    run_load(1'b0, nb, order_ok, stable_ok, gap, fb, lb);
    run_wait(4, extra);
    run_read(1'b0, 20, nr);
    tests++;
    if (nr !== 20 || core_data_out_ready !== 1'b1 || perf_cycles !== 32'd4) begin
      fails++;
      $display("FAIL midread_setup: beats=%0d ready=%b perf=%0d expected 20 1 4",
               nr, core_data_out_ready, perf_cycles);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0 || core_data_out_ready !== 1'b0 || perf_cycles !== '0 ||
        rsp_state !== '0 || core_start !== 1'b0) begin
      fails++;
      $display("FAIL midread_reset: valid=%b oready=%b perf=%0d expected 0 0 0",
               rsp_valid, core_data_out_ready, perf_cycles);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || core_data_in_valid !== 1'b0) begin
      fails++;
      $display("FAIL midread_idle: ready=%b din_valid=%b expected 1 0", req_ready, core_data_in_valid);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_state = '0; rsp_ready = 1'b0;
    core_data_in_ready = 1'b1; core_data_out = '0; core_data_out_valid = 1'b0;
    core_finish = 1'b0; core_free = 1'b1;
    for (int i = 0; i < int'(NB); i++) begin
      pattern_in[i*8 +: 8]  = 8'(i + 1);
      pattern_out[i*8 +: 8] = 8'(8'hA0 + i);
    end
    @(negedge clk);
    test_reset();
    test_load_no_stall();
    test_stall_wait_read();
    test_resp_backpressure();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
